// File: rtl/seq_cont_chain.sv
// Multi-channel b -> c[DEPTH] -> a feedback chain with a run controller measuring settle time.
// Optional build macro SEQ_CONT_BYPASS_EN makes a follow c combinationally (latency DEPTH).
module seq_cont_chain #(
    parameter int WIDTH      = 1,
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 2,
    parameter int SETTLE_MAX = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] init_val,
    output logic [CHANNELS*WIDTH-1:0] a_out,
    output logic [CHANNELS*WIDTH-1:0] b_out,
    output logic [CHANNELS*WIDTH-1:0] c_out,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                settle_cycles,
    output logic                      timeout
);
    localparam int VW = CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t                   state_q;
    logic [7:0]               cnt_q;
    logic [7:0]               settle_q;
    logic                     timeout_q;
    logic                     busy_q;
    logic                     done_q;
    logic [VW-1:0]            b_q;
    logic [DEPTH-1:0][VW-1:0] c_q;
    logic [DEPTH-1:0][VW-1:0] c_d;
    logic [DEPTH-1:0]         cv_q;
    logic [DEPTH-1:0]         cv_d;
    logic [VW-1:0]            a_cur;
    logic                     av_cur;
    logic [CHANNELS-1:0]      ch_match;
    logic                     match;
    logic                     accept;

    assign accept = (state_q == IDLE) && start;

    // b only tracks init_val on the accepting edge and while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (accept || (state_q == RUN)) begin
            b_q <= init_val;
        end
    end

    // Delay pipeline next-state; accepting a run clears every valid bit
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign c_d[gi]  = b_q;
            assign cv_d[gi] = !accept;
        end else begin : g_rest
            assign c_d[gi]  = c_q[gi-1];
            assign cv_d[gi] = cv_q[gi-1] && !accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q  <= '0;
            cv_q <= '0;
        end else begin
            c_q  <= c_d;
            cv_q <= cv_d;
        end
    end

`ifdef SEQ_CONT_BYPASS_EN
    assign a_cur  = c_q[DEPTH-1];
    assign av_cur = cv_q[DEPTH-1];
`else
    logic [VW-1:0] a_q;
    logic          av_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            av_q <= 1'b0;
        end else begin
            a_q  <= c_q[DEPTH-1];
            av_q <= cv_q[DEPTH-1] && !accept;
        end
    end

    assign a_cur  = a_q;
    assign av_cur = av_q;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_match
        assign ch_match[gi] = (a_cur[gi*WIDTH +: WIDTH] == b_q[gi*WIDTH +: WIDTH]);
    end

    assign match = av_cur && (&ch_match);

    // Run controller; a match takes priority over a simultaneous timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            settle_q  <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    if (match) begin
                        state_q  <= DONE_ST;
                        settle_q <= cnt_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (cnt_q == 8'(SETTLE_MAX)) begin
                        state_q   <= DONE_ST;
                        settle_q  <= 8'(SETTLE_MAX);
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE_ST: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out         = a_cur;
    assign b_out         = b_q;
    assign c_out         = c_q[DEPTH-1];
    assign busy          = busy_q;
    assign done          = done_q;
    assign settle_cycles = settle_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_seq_cont_chain.sv
// Directed bench for seq_cont_chain: reset, settle, mid-run change, timeout, reset mid-run.
module tb_seq_cont_chain;
    localparam int W  = 1;
    localparam int CH = 4;
    localparam int D  = 2;
    localparam int SM = 10;
`ifdef SEQ_CONT_BYPASS_EN
    localparam int LAT  = D;
    localparam int HALF = 2;
`else
    localparam int LAT  = D + 1;
    localparam int HALF = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CH*W-1:0]   init_val = '0;
    logic [CH*W-1:0]   a_out, b_out, c_out;
    logic              busy, done, timeout;
    logic [7:0]        settle_cycles;

    int n_vec = 0;
    int n_err = 0;

    seq_cont_chain #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .SETTLE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_val(init_val),
        .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .busy(busy), .done(done), .settle_cycles(settle_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < bound) begin
            tick();
            edges++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic launch(input logic [CH*W-1:0] v);
        init_val = v;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int  edges;
        logic seen;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {17'd0, a_out, b_out, c_out, busy, done, timeout}, 32'd0);
        chk("rst_settle", {24'd0, settle_cycles}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | done | busy;
        end
        chk("idle_quiet", {31'd0, seen}, 32'd0);

        // Basic settle
        launch(4'hF);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(20, edges);
        chk("basic_edges", edges, LAT + 1);
        chk("basic_settle", {24'd0, settle_cycles}, LAT);
        chk("basic_timeout", {31'd0, timeout}, 32'd0);
        chk("basic_abc", {20'd0, a_out, b_out, c_out}, 32'hFFF);
        tick();
        chk("basic_done_pulse", {30'd0, done, busy}, 32'd0);

        // Mid-run change of init_val
        launch(4'h5);
        init_val = 4'hA;
        wait_done(20, edges);
        chk("mid_edges", edges, LAT + 2);
        chk("mid_settle", {24'd0, settle_cycles}, LAT + 1);
        chk("mid_a", {28'd0, a_out}, 32'hA);
        tick();

        // Timeout with a toggling input
        launch(4'h0);
        edges = 0;
        while (done !== 1'b1 && edges < 25) begin
            init_val = (((edges + 1) / HALF) % 2 != 0) ? 4'hF : 4'h0;
            tick();
            edges++;
        end
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_edges", edges, SM + 1);
        chk("to_flag", {31'd0, timeout}, 32'd1);
        chk("to_settle", {24'd0, settle_cycles}, SM);
        init_val = 4'h0;
        tick();
        tick();
        chk("to_held", {31'd0, timeout}, 32'd1);

        // Reset mid-run, then a fresh run
        launch(4'h5);
        chk("restart_clears_to", {30'd0, timeout, busy}, 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {17'd0, a_out, b_out, c_out, busy, done, timeout}, 32'd0);
        chk("midrst_settle", {24'd0, settle_cycles}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(4'h3);
        wait_done(20, edges);
        chk("post_settle", {24'd0, settle_cycles}, LAT);
        chk("post_ab", {24'd0, a_out, b_out}, 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_cont_chain.md
# seq_cont_chain

Parametrised, synthesisable successor to the single-bit procedural/continuous feedback scheduling example. Each channel has a driven register `b`, a continuous-style delay path `c` that follows `b` through `DEPTH` registered stages, and a capture register `a` that follows `c`. A run controller measures how many cycles all channels take to settle (`a == b` with valid data) and flags a timeout if they do not settle. The block sits among the scheduling examples as a deterministic, cycle-exact reference for feedback ordering.

## Interface
- `WIDTH`, 1, bits per channel
- `CHANNELS`, 4, number of independent channels (≥1)
- `DEPTH`, 2, registered stages from `b` to `c` (≥1)
- `SETTLE_MAX`, 255, timeout limit in cycles (1..255)

- `clk` input 1: single clock; all state updates on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: begins a run when sampled high in IDLE
- `init_val` input CHANNELS*WIDTH: value driven into `b`; channel k is bits [k*WIDTH +: WIDTH]
- `a_out`, `b_out`, `c_out` output CHANNELS*WIDTH: per-channel `a`, `b`, `c`, same packing as `init_val`
- `busy` output 1: high in RUN
- `done` output 1: one-cycle pulse when a run ends
- `settle_cycles` output 8: result of the last run
- `timeout` output 1: result flag of the last run, held until the next start

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE on a match or on a timeout.
  - DONE→IDLE unconditionally after one cycle.
- `start` is ignored outside IDLE.
- Start-acceptance edge E0:
  - `b <= init_val`
  - all valid bits clear, then begin shifting
  - counter `<= 0`; `timeout <= 0`
- In RUN, on every edge:
  - `b <= init_val`, so a live input change restarts settling.
  - The `c` pipeline shifts `b` one stage, with a parallel valid bit.
  - `a <= c`; `a`-valid `<= c`-valid.
  - The counter increments and saturates at 255.
- Match condition, evaluated from registered state in RUN: every channel has `a`-valid set and `a == b`.
- When a match is seen in a RUN cycle:
  - The next edge enters DONE.
  - `settle_cycles <=` counter value, i.e. the number of edges from E0 to the edge that produced the match.
- When the counter equals `SETTLE_MAX` with no match, the next edge enters DONE with `timeout <= 1` and `settle_cycles <= SETTLE_MAX`.
- Match and timeout in the same cycle: match wins, `timeout = 0`.
- `done` = 1 exactly while in DONE.
- In IDLE and DONE:
  - `b` holds.
  - The pipeline and `a` keep shifting, so outputs continue to settle visibly.
- Reset, asynchronous and at any time including mid-run, forces:
  - `a`, `b`, all `c` stages and valid bits to 0
  - FSM to IDLE
  - `busy`, `done`, `timeout` to 0; `settle_cycles` to 0

## Timing
- Without bypass, a constant `init_val` gives:
  - `c` = `b` after DEPTH edges
  - `a` = `b` after DEPTH+1 edges, so `settle_cycles = DEPTH+1`
- `done` is high during the cycle after edge E(settle_cycles+1).
- `busy` is high from after E0 until entry to DONE.
- A change of `init_val` at cycle t restarts the DEPTH+1 latency from the edge that captures it. The counter is not reset.
- Minimum start-to-start spacing: settle_cycles + 3 edges.

## Configuration
- `SEQ_CONT_BYPASS_EN` defined:
  - `a` becomes a continuous assignment `a = c`, with valid following `c`-valid combinationally.
  - This models the zero-delay, re-evaluated procedural read.
  - Settle latency is DEPTH, so `settle_cycles = DEPTH`.
- Undefined (default): `a` is registered as described above; latency is DEPTH+1.
- The FSM, counter and reset behaviour are identical in both builds.

## Test plan
- Reset then idle: `rst_n` low 3 cycles then high, no start. Required response:
  - all outputs 0
  - `busy = 0`, `done` never pulses
- Basic settle (CHANNELS=4, WIDTH=1, DEPTH=2, default build): start with `init_val = 4'b1111`. Required response:
  - `done` pulses once
  - `settle_cycles = 3`, `timeout = 0`
  - `a_out = b_out = c_out = 4'hF`
- Bypass build, same stimulus: `settle_cycles = 2`.
- Mid-run change: start with `4'b0101`; after 1 cycle drive `4'b1010`. Required response: `settle_cycles = 4`, `a_out = 4'hA`.
- Timeout (SETTLE_MAX=10): toggle `init_val` between `4'h0` and `4'hF` every cycle. Required response: `done` with `timeout = 1`, `settle_cycles = 10`.
- Reset mid-run: assert `rst_n` low 2 edges after start. Required response:
  - everything returns to 0 and IDLE immediately
  - a new start with `4'h3` yields `settle_cycles = 3`
